// File: rtl/reg_dump_uart.sv
// Dumps all 32 CPU registers as ASCII hex records over a UART transmitter (8N1).
// Define REG_DUMP_CRLF_EN to end each record with CR LF instead of a single space.
module reg_dump_uart #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [4:0]  reg_sel,
  input  logic [31:0] reg_data,
  output logic        tx,
  output logic        busy,
  output logic        done,
  output logic [2:0]  state_dbg
);

`ifdef REG_DUMP_CRLF_EN
  localparam int NUM_BYTES = 10;
`else
  localparam int NUM_BYTES = 9;
`endif
  localparam logic [15:0] BAUD_RELOAD = 16'(CLKS_PER_BIT - 1);
  localparam logic [3:0]  LAST_BYTE   = 4'(NUM_BYTES - 1);

  typedef enum logic [2:0] {IDLE, SEL, CAPT, SEND, NEXT} state_t;

  state_t      state, state_nx;
  logic [4:0]  index;
  logic [31:0] shadow;
  logic [3:0]  byte_cnt;
  logic [3:0]  bit_cnt;
  logic [15:0] baud_cnt;
  logic        bit_end, frame_end, byte_last;
  logic [31:0] shifted;
  logic [3:0]  nibble;
  logic [7:0]  tx_byte;
  logic        frame_bit;

  assign reg_sel   = index;
  assign state_dbg = state;
  assign bit_end   = (baud_cnt == 16'd0);
  assign frame_end = bit_end && (bit_cnt == 4'd9);
  assign byte_last = (byte_cnt == LAST_BYTE);

  // Character of the current record byte: hex digits MSB nibble first, then separator.
  always_comb begin
    shifted = shadow << {byte_cnt[2:0], 2'b00};
    nibble  = shifted[31:28];
    tx_byte = 8'h20;
    if (byte_cnt < 4'd8) begin
      tx_byte = (nibble < 4'd10) ? {4'h3, nibble} : (8'h37 + {4'h0, nibble});
    end else begin
`ifdef REG_DUMP_CRLF_EN
      tx_byte = (byte_cnt == 4'd8) ? 8'h0D : 8'h0A;
`else
      tx_byte = 8'h20;
`endif
    end
  end

  // Bit slot 0 is the start bit, 1..8 carry data LSB first, 9 is the stop bit.
  always_comb begin
    frame_bit = 1'b1;
    if (bit_cnt == 4'd0) begin
      frame_bit = 1'b0;
    end else if (bit_cnt <= 4'd8) begin
      frame_bit = tx_byte[3'(bit_cnt - 4'd1)];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b1;
    done     = 1'b0;
    tx       = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nx = SEL;
      end
      SEL:  state_nx = CAPT;
      CAPT: state_nx = SEND;
      SEND: begin
        tx = frame_bit;
        if (frame_end && byte_last) state_nx = NEXT;
      end
      NEXT: begin
        if (index == 5'd31) begin
          done     = 1'b1;
          state_nx = IDLE;
        end else begin
          state_nx = SEL;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      index    <= 5'd0;
      shadow   <= 32'd0;
      byte_cnt <= 4'd0;
      bit_cnt  <= 4'd0;
      baud_cnt <= 16'd0;
    end else begin
      case (state)
        IDLE: if (start) index <= 5'd0;
        CAPT: begin
          shadow   <= reg_data;
          byte_cnt <= 4'd0;
          bit_cnt  <= 4'd0;
          baud_cnt <= BAUD_RELOAD;
        end
        SEND: begin
          // Reload at every bit boundary so frame timing never accumulates error.
          if (bit_end) begin
            baud_cnt <= BAUD_RELOAD;
            if (bit_cnt == 4'd9) begin
              bit_cnt <= 4'd0;
              if (!byte_last) byte_cnt <= byte_cnt + 4'd1;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        NEXT: if (index != 5'd31) index <= index + 5'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/reg_dump_uart.md
REG_DUMP_UART -- requirements
Module: reg_dump_uart

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868: clk cycles per UART bit (115200 baud at 100 MHz); legal range 2..65535.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  single-cycle request to dump all 32 registers.
REQ-005 SHALL have port reg_sel  output  5  register index driven to the CPU register-readback port.
REQ-006 SHALL have port reg_data  input  32  register value returned by the CPU for reg_sel, combinational from reg_sel.
REQ-007 SHALL have port tx  output  1  UART serial line; idle level 1.
REQ-008 SHALL have port busy  output  1  high from accepted start until the dump completes.
REQ-009 SHALL have port done  output  1  one-cycle pulse after the final stop bit of register 31.

Function
REQ-010 SHALL implement FSM states IDLE, SEL, CAPT, SEND, NEXT.
REQ-011 IDLE: start=1 -> SEL with index=0 and busy=1 on the next edge; start=0 -> stay in IDLE.
REQ-012 SEL: drive reg_sel=index for one cycle -> CAPT.
REQ-013 CAPT: latch reg_data into a 32-bit shadow register and clear the byte counter -> SEND.
REQ-014 SEND: transmit the record bytes of REQ-016 back-to-back, no idle gap between frames; after the last byte -> NEXT.
REQ-015 NEXT: index<31 -> index+1 and go to SEL; index=31 -> done=1 for one cycle, busy=0, go to IDLE.
REQ-016 Record per register: 8 ASCII hex characters, most-significant nibble first, uppercase ('0'-'9' = 0x30-0x39, 'A'-'F' = 0x41-0x46), followed by the separator of REQ-026/027.
REQ-017 Frame: start bit 0, 8 data bits LSB first, stop bit 1; each bit held exactly CLKS_PER_BIT cycles.
REQ-018 Bit timing SHALL use a down-counter reloaded at each bit boundary; no cumulative drift across frames.
REQ-019 Captured value SHALL be taken from the shadow register only; reg_data changes during SEND SHALL NOT alter output.
REQ-020 start while busy=1 SHALL be ignored, including in the cycle done=1.
REQ-021 reg_sel SHALL hold its last driven index outside SEL.
REQ-022 tx SHALL be 1 in IDLE, SEL, CAPT and NEXT.

Reset
REQ-023 Reset assertion SHALL immediately force state=IDLE, tx=1, busy=0, done=0, reg_sel=0, index=0, and clear all counters and the shadow register.
REQ-024 Reset mid-frame SHALL truncate the frame with tx=1 at once; no partial frame resumes after release.
REQ-025 First start accepted SHALL be on the first clk edge after reset deasserts.

Configuration
REQ-026 With macro REG_DUMP_CRLF_EN defined, the separator SHALL be CR (0x0D) then LF (0x0A), giving 10 bytes per register.
REQ-027 Without REG_DUMP_CRLF_EN, the separator SHALL be a single space (0x20), giving 9 bytes per register.

Verification
REQ-028 CLKS_PER_BIT=4, CRLF_EN on, reg 0 = 0x000000AF -> first record decodes as 0x30 x6, 0x41, 0x46, 0x0D, 0x0A; each bit 4 cycles wide.
REQ-029 CLKS_PER_BIT=4, CRLF_EN on, reg k = 0x1000_0000+k -> 320 frames, record 31 reads "1000001F\r\n", done pulses once, busy=0 the cycle after done.
REQ-030 CLKS_PER_BIT=4, CRLF_EN off -> 288 frames total, every ninth byte is 0x20.
REQ-031 start pulsed again during register 5 -> no restart, frame count unchanged, exactly one done pulse.
REQ-032 reset asserted mid stop bit of register 3 -> tx=1, busy=0, reg_sel=0 within the same cycle; new start produces a full dump beginning at register 0.
REQ-033 reg_data toggled every cycle during SEND of register 2 -> transmitted characters equal the value present in CAPT.
